// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master:
//   - spi_state_e : transfer FSM states (IDLE, SETUP, HIGH, LOW)
//   - BIT_W       : bits per transfer (8)
//   - DIV_W       : width of the half-period down-counter (8)
//   - rotl1       : one-bit left rotate used for the tx shift register
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int BIT_W = 8;
  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } spi_state_e;

  // Rotating rather than shifting keeps every register bit in use; the byte
  // returns to its original alignment after BIT_W falling edges.
  function automatic logic [BIT_W-1:0] rotl1(input logic [BIT_W-1:0] v);
    return {v[BIT_W-2:0], v[BIT_W-1]};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Half-period timer for the SPI master. A down-counter is reloaded with
// CLK_DIV-1 whenever the FSM changes state, so every state lasts exactly
// CLK_DIV clk cycles. tick is high in the last cycle of each period.
// Ports:
//   clk    : system clock (rising edge)
//   rst_n  : synchronous active-low reset
//   reload : FSM state change this cycle; restart the period
//   tick   : one-cycle strobe at the end of each CLK_DIV-cycle period
// -----------------------------------------------------------------------------
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  output logic tick
);

  localparam logic [DIV_W-1:0] LOAD = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_r;

  // Down-counter: reload on state change or when a period expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (reload || (cnt_r == {DIV_W{1'b0}})) begin
      cnt_r <= LOAD;
    end else begin
      cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (cnt_r == {DIV_W{1'b0}});

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Single-byte SPI master, mode 0 (SCLK idle low, sample on rising edge,
// shift on falling edge), MSB first. SCLK half-period is CLK_DIV clk cycles;
// a transfer accepted at cycle 0 raises done at cycle 1+17*CLK_DIV.
// Optional feature macro: SPI_MASTER_RX_EN
//   defined   : miso is shifted in and presented on rx_data at done
//   undefined : no receive path, miso unused, rx_data tied to 8'h00
// Ports:
//   clk     : system clock (rising edge)
//   rst_n   : synchronous active-low reset
//   start   : transfer request, sampled only in IDLE
//   tx_data : byte to send, captured on acceptance
//   rx_data : last received byte
//   busy    : transfer in progress
//   done    : one-cycle end-of-transfer pulse
//   sclk    : SPI clock
//   mosi    : serial data out
//   miso    : serial data in
//   cs_n    : active-low chip select
// -----------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIT_W-1:0] tx_data,
  output logic [BIT_W-1:0] rx_data,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  spi_state_e       state_r, state_s;
  logic [BIT_W-1:0] tx_sr_r, tx_sr_s;
  logic [2:0]       bit_cnt_r, bit_cnt_s;
  logic             sclk_r, sclk_s;
  logic             cs_n_r, cs_n_s;
  logic             mosi_r, mosi_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             rise_s;   // sclk goes 0->1 at this edge
  logic             fin_s;    // LOW->IDLE at this edge
  logic             tick_s;
  logic             reload_s;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (reload_s),
    .tick   (tick_s)
  );

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s   = state_r;
    tx_sr_s   = tx_sr_r;
    bit_cnt_s = bit_cnt_r;
    sclk_s    = sclk_r;
    cs_n_s    = cs_n_r;
    mosi_s    = mosi_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    rise_s    = 1'b0;
    fin_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s   = SETUP;
          tx_sr_s   = tx_data;
          bit_cnt_s = 3'd0;
          sclk_s    = 1'b0;
          cs_n_s    = 1'b0;
          busy_s    = 1'b1;
          mosi_s    = tx_data[BIT_W-1];
        end else begin
          sclk_s = 1'b0;
          cs_n_s = 1'b1;
          busy_s = 1'b0;
          mosi_s = 1'b0;
        end
      end
      SETUP: begin
        if (tick_s) begin
          state_s = HIGH;
          sclk_s  = 1'b1;
          rise_s  = 1'b1;
        end else begin
          state_s = SETUP;
        end
      end
      HIGH: begin
        if (tick_s) begin
          // Falling edge: present the next bit; the counter wraps to 0 on
          // the 8th fall, which marks the final LOW phase.
          state_s   = LOW;
          sclk_s    = 1'b0;
          tx_sr_s   = rotl1(tx_sr_r);
          mosi_s    = tx_sr_r[BIT_W-2];
          bit_cnt_s = bit_cnt_r + 3'd1;
        end else begin
          state_s = HIGH;
        end
      end
      LOW: begin
        if (tick_s) begin
          if (bit_cnt_r == 3'd0) begin
            state_s = IDLE;
            cs_n_s  = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            mosi_s  = 1'b0;
            fin_s   = 1'b1;
          end else begin
            state_s = HIGH;
            sclk_s  = 1'b1;
            rise_s  = 1'b1;
          end
        end else begin
          state_s = LOW;
        end
      end
      default: begin
        state_s = IDLE;
        sclk_s  = 1'b0;
        cs_n_s  = 1'b1;
        busy_s  = 1'b0;
        mosi_s  = 1'b0;
      end
    endcase
    reload_s = (state_s != state_r);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      tx_sr_r   <= {BIT_W{1'b0}};
      bit_cnt_r <= 3'd0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      tx_sr_r   <= tx_sr_s;
      bit_cnt_r <= bit_cnt_s;
      sclk_r    <= sclk_s;
      cs_n_r    <= cs_n_s;
      mosi_r    <= mosi_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign sclk = sclk_r;
  assign cs_n = cs_n_r;
  assign mosi = mosi_r;
  assign busy = busy_r;
  assign done = done_r;

`ifdef SPI_MASTER_RX_EN
  logic [BIT_W-1:0] rx_sr_r;
  logic [BIT_W-1:0] rx_data_r;

  // Receive path: shift miso in on each rising sclk, publish at end of byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sr_r   <= {BIT_W{1'b0}};
      rx_data_r <= {BIT_W{1'b0}};
    end else begin
      if (rise_s) begin
        rx_sr_r <= {rx_sr_r[BIT_W-2:0], miso};
      end else begin
        rx_sr_r <= rx_sr_r;
      end
      if (fin_s) begin
        rx_data_r <= rx_sr_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign rx_data = rx_data_r;
`else
  // No receive path: these strobes and miso are intentionally left unused.
  logic unused_rx_s;
  assign unused_rx_s = miso ^ rise_s ^ fin_s;
  assign rx_data     = {BIT_W{1'b0}};
`endif

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Directed bench for spi_master. Two instances (CLK_DIV=4 and CLK_DIV=1)
// share clk/rst_n; sel routes start to one of them and selects which one's
// outputs are observed. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_master;

`ifdef SPI_MASTER_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] tx;
  logic       sel;        // 0: CLK_DIV=4 instance, 1: CLK_DIV=1 instance
  logic [1:0] mode;       // miso: 0 tied 0, 1 tied 1, 2 loopback, 3 toggle
  logic       tog = 1'b0;

  logic [7:0] rx4, rx1;
  logic       busy4, busy1, done4, done1, sclk4, sclk1;
  logic       mosi4, mosi1, cs4, cs1, miso4, miso1;

  always #5 clk = ~clk;

  // Free-running toggle source for the "miso toggling" case.
  always @(posedge clk) tog <= ~tog;

  assign miso4 = (mode == 2'd2) ? mosi4 : (mode == 2'd3) ? tog : mode[0];
  assign miso1 = (mode == 2'd2) ? mosi1 : (mode == 2'd3) ? tog : mode[0];

  spi_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .tx_data(tx),
    .rx_data(rx4), .busy(busy4), .done(done4), .sclk(sclk4),
    .mosi(mosi4), .miso(miso4), .cs_n(cs4)
  );

  spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .tx_data(tx),
    .rx_data(rx1), .busy(busy1), .done(done1), .sclk(sclk1),
    .mosi(mosi1), .miso(miso1), .cs_n(cs1)
  );

  wire [7:0] o_rx   = sel ? rx1   : rx4;
  wire       o_busy = sel ? busy1 : busy4;
  wire       o_done = sel ? done1 : done4;
  wire       o_sclk = sel ? sclk1 : sclk4;
  wire       o_mosi = sel ? mosi1 : mosi4;
  wire       o_cs   = sel ? cs1   : cs4;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run observations gathered by step().
  int          cyc, ndone, first_done, npulse, hi_len, min_hi, max_hi, idle_bad;
  logic [15:0] mosi_bits;
  logic        prev_sclk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; ndone = 0; first_done = -1; npulse = 0; hi_len = 0;
    min_hi = 9999; max_hi = 0; idle_bad = 0; mosi_bits = 16'h0000;
    prev_sclk = o_sclk;
  endtask

  // Advance one clk and record what the observed instance did in that cycle.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc++;
    if (o_done) begin
      ndone++;
      if (first_done < 0) first_done = cyc;
    end
    if (o_sclk && !prev_sclk) begin
      mosi_bits = {mosi_bits[14:0], o_mosi};
      npulse++;
      hi_len = 1;
    end else if (o_sclk) begin
      hi_len++;
    end else if (prev_sclk) begin
      if (hi_len < min_hi) min_hi = hi_len;
      if (hi_len > max_hi) max_hi = hi_len;
    end
    if (o_cs && o_mosi) idle_bad++;
    prev_sclk = o_sclk;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx = 8'h00; sel = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", o_cs, 1);
    check_eq("rst_sclk", o_sclk, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_mosi", o_mosi, 0);
    check_eq("rst_rx",   o_rx, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // A5 with loopback, CLK_DIV=4
    clear_stats(); sel = 1'b0; mode = 2'd2; tx = 8'hA5; start = 1'b1;
    step();
    check_eq("a5_c1_cs_n", o_cs, 0);
    check_eq("a5_c1_busy", o_busy, 1);
    check_eq("a5_c1_mosi", o_mosi, 1);
    while (cyc < 100) step();
    check_eq("a5_done_cyc", first_done, 69);
    check_eq("a5_ndone",    ndone, 1);
    check_eq("a5_mosi",     mosi_bits[7:0], 8'hA5);
    check_eq("a5_pulses",   npulse, 8);
    check_eq("a5_min_hi",   min_hi, 4);
    check_eq("a5_max_hi",   max_hi, 4);
    check_eq("a5_rx",       o_rx, RX_EN ? 8'hA5 : 8'h00);
    check_eq("a5_end_cs_n", o_cs, 1);
    check_eq("a5_end_busy", o_busy, 0);
    check_eq("a5_idle_mosi", idle_bad, 0);

    // 3C, miso tied 1, CLK_DIV=1
    clear_stats(); sel = 1'b1; mode = 2'd1; tx = 8'h3C; start = 1'b1;
    while (cyc < 40) step();
    check_eq("d1_done_cyc", first_done, 18);
    check_eq("d1_pulses",   npulse, 8);
    check_eq("d1_min_hi",   min_hi, 1);
    check_eq("d1_max_hi",   max_hi, 1);
    check_eq("d1_mosi",     mosi_bits[7:0], 8'h3C);
    check_eq("d1_rx",       o_rx, RX_EN ? 8'hFF : 8'h00);
    check_eq("d1_idle_mosi", idle_bad, 0);

    // Start pulses while busy are ignored; tx_data changes have no effect
    clear_stats(); sel = 1'b0; mode = 2'd0; tx = 8'hC3; start = 1'b1;
    while (cyc < 120) begin
      step();
      if (cyc == 5 || cyc == 20) begin
        start = 1'b1;
        tx    = 8'h5A;
      end
    end
    check_eq("ign_ndone",    ndone, 1);
    check_eq("ign_done_cyc", first_done, 69);
    check_eq("ign_mosi",     mosi_bits[7:0], 8'hC3);
    check_eq("ign_pulses",   npulse, 8);
    check_eq("ign_rx",       o_rx, 8'h00);

    // Back-to-back: 01 then 80 started in the done cycle
    begin
      int  gap;
      bit  chained;
      gap = 0; chained = 1'b0;
      clear_stats(); sel = 1'b0; mode = 2'd2; tx = 8'h01; start = 1'b1;
      while (cyc < 170) begin
        step();
        if (ndone == 1 && o_cs) gap++;
        if (o_done && ndone == 1 && !chained) begin
          start   = 1'b1;
          tx      = 8'h80;
          chained = 1'b1;
        end
      end
      check_eq("b2b_cs_gap",   gap, 1);
      check_eq("b2b_ndone",    ndone, 2);
      check_eq("b2b_first",    first_done, 69);
      check_eq("b2b_mosi",     mosi_bits, 16'h0180);
      check_eq("b2b_pulses",   npulse, 16);
      check_eq("b2b_rx",       o_rx, RX_EN ? 8'h80 : 8'h00);
    end

    // Reset asserted at cycle 30 of a transfer
    clear_stats(); sel = 1'b0; mode = 2'd1; tx = 8'hF0; start = 1'b1;
    while (cyc < 120) begin
      step();
      if (cyc == 30) begin
        check_eq("rstm_busy_before", o_busy, 1);
        rst_n = 1'b0;
      end else if (cyc == 31) begin
        check_eq("rstm_cs_n", o_cs, 1);
        check_eq("rstm_sclk", o_sclk, 0);
        check_eq("rstm_busy", o_busy, 0);
        check_eq("rstm_mosi", o_mosi, 0);
        check_eq("rstm_rx",   o_rx, 8'h00);
        rst_n = 1'b1;
      end
    end
    check_eq("rstm_ndone", ndone, 0);

    // FF with toggling miso: timing as for A5
    clear_stats(); sel = 1'b0; mode = 2'd3; tx = 8'hFF; start = 1'b1;
    while (cyc < 100) step();
    check_eq("ff_done_cyc", first_done, 69);
    check_eq("ff_mosi",     mosi_bits[7:0], 8'hFF);
    check_eq("ff_pulses",   npulse, 8);
`ifndef SPI_MASTER_RX_EN
    check_eq("ff_rx_tied",  o_rx, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
